// File: rtl/nco_ctrl_pkg.sv
// Shared types for the NCO frequency-sweep controller.
package nco_ctrl_pkg;

    localparam int PHASE_W_DEF = 32;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sweep_state_t;

    typedef struct packed {
        logic [PHASE_W_DEF-1:0] f_start;
        logic [PHASE_W_DEF-1:0] f_step;
        logic [CNT_W_DEF-1:0]   n_steps;
        logic [CNT_W_DEF-1:0]   dwell;
        logic                   repeat_en;
    } sweep_cfg_t;

endpackage

// File: rtl/nco_sweep_ctrl_dwell_timer.sv
// Loadable down-counter that times how long each tuning word is held.
module dwell_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Sweeps the NCO tuning word from a start value in signed steps,
// holding each word for a programmable dwell.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic               repeat_en,
    input  logic [PHASE_W-1:0] f_start,
    input  logic [PHASE_W-1:0] f_step,
    input  logic [CNT_W-1:0]   n_steps,
    input  logic [CNT_W-1:0]   dwell,
    output logic [PHASE_W-1:0] phase_inc,
    output logic               busy,
    output logic               done,
    output logic               step_strobe,
    output logic [CNT_W-1:0]   step_idx
);

    sweep_state_t state, state_nx;
    sweep_cfg_t   cfg;

    logic             do_load;
    logic             do_reload;
    logic             do_step;
    logic             do_done;
    logic             tmr_zero;
    logic             tmr_en;
    logic [CNT_W-1:0] dwell_eff;
    logic [CNT_W-1:0] tmr_val;

    // A dwell of zero behaves as a single-cycle hold.
    assign dwell_eff = (dwell == '0) ? CNT_W'(1) : dwell;
    assign tmr_val   = do_load ? dwell_eff - CNT_W'(1)
                               : cfg.dwell - CNT_W'(1);
    assign tmr_en    = (state == ST_RUN) && !pause;

    dwell_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (do_load | do_reload | do_step),
        .load_val(tmr_val),
        .en      (tmr_en),
        .zero    (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        do_load   = 1'b0;
        do_reload = 1'b0;
        do_step   = 1'b0;
        do_done   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nx = ST_RUN;
                    do_load  = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (!pause && tmr_zero) begin
                    if (step_idx < cfg.n_steps) begin
                        do_step = 1'b1;
                    end else begin
                        do_done = 1'b1;
                        if (cfg.repeat_en) begin
                            do_reload = 1'b1;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg         <= '0;
            phase_inc   <= '0;
            step_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            step_strobe <= 1'b0;
        end else begin
            busy        <= (state_nx == ST_RUN);
            done        <= do_done;
            step_strobe <= do_load | do_reload | do_step;
            if (do_load) begin
                cfg.f_start   <= f_start;
                cfg.f_step    <= f_step;
                cfg.n_steps   <= n_steps;
                cfg.dwell     <= dwell_eff;
                cfg.repeat_en <= repeat_en;
                phase_inc     <= f_start;
                step_idx      <= '0;
            end else if (do_reload) begin
                phase_inc <= cfg.f_start;
                step_idx  <= '0;
            end else if (do_step) begin
                phase_inc <= phase_inc + cfg.f_step;
                step_idx  <= step_idx + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed self-checking bench for nco_sweep_ctrl.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        pause;
    logic        repeat_en;
    logic [31:0] f_start;
    logic [31:0] f_step;
    logic [15:0] n_steps;
    logic [15:0] dwell;
    logic [31:0] phase_inc;
    logic        busy;
    logic        done;
    logic        step_strobe;
    logic [15:0] step_idx;

    int n_assert = 0;
    int n_fail   = 0;

    nco_sweep_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pause      (pause),
        .repeat_en  (repeat_en),
        .f_start    (f_start),
        .f_step     (f_step),
        .n_steps    (n_steps),
        .dwell      (dwell),
        .phase_inc  (phase_inc),
        .busy       (busy),
        .done       (done),
        .step_strobe(step_strobe),
        .step_idx   (step_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ph,
                           input logic [15:0] idx, input logic bz,
                           input logic dn, input logic st);
        chk({tag, ".phase"}, phase_inc, ph);
        chk({tag, ".idx"}, {16'h0, step_idx}, {16'h0, idx});
        chk({tag, ".busy"}, {31'h0, busy}, {31'h0, bz});
        chk({tag, ".done"}, {31'h0, done}, {31'h0, dn});
        chk({tag, ".strobe"}, {31'h0, step_strobe}, {31'h0, st});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
        repeat_en = 1'b0; f_start = '0; f_step = '0;
        n_steps = '0; dwell = '0;
        tick();
        tick();
        chk_all("reset", 32'h0, 16'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();

        // one-shot sweep, with ignored start and config change mid-sweep
        f_start = 32'h1000; f_step = 32'h100; n_steps = 16'd3;
        dwell = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk_all("oneshot", 32'h1000 + 32'h100 * 32'(k / 4),
                    16'(k / 4), 1'b1, 1'b0, (k % 4) == 0);
            if (k == 1) begin
                start = 1'b1; f_start = 32'hDEAD0000; f_step = 32'h5;
            end
            if (k == 2) start = 1'b0;
            tick();
        end
        chk_all("oneshot_end", 32'h1300, 16'd3, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("oneshot_idle", 32'h1300, 16'd3, 1'b0, 1'b0, 1'b0);

        // negative step with wrap, dwell 0
        f_start = 32'h80; f_step = 32'hFFFFFF00; n_steps = 16'd1;
        dwell = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("neg0", 32'h80, 16'd0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("neg1", 32'hFFFFFF80, 16'd1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("neg_end", 32'hFFFFFF80, 16'd1, 1'b0, 1'b1, 1'b0);

        // repeat mode, then abort
        f_start = 32'h2000; f_step = 32'h10; n_steps = 16'd1;
        dwell = 16'd2; repeat_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; repeat_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk_all("repeat",
                    ((k / 2) % 2 == 1) ? 32'h2010 : 32'h2000,
                    16'((k / 2) % 2), 1'b1,
                    (k > 0) && (k % 4 == 0), (k % 2) == 0);
            if (k < 9) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_all("abort", 32'h2000, 16'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("abort_idle", 32'h2000, 16'd0, 1'b0, 1'b0, 1'b0);

        // pause for 5 cycles mid-dwell
        f_start = 32'h3000; f_step = 32'h100; n_steps = 16'd2;
        dwell = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            chk_all("pause",
                    (k < 8) ? 32'h3000 : (k < 11) ? 32'h3100 : 32'h3200,
                    (k < 8) ? 16'd0 : (k < 11) ? 16'd1 : 16'd2, 1'b1,
                    1'b0, (k == 0) || (k == 8) || (k == 11));
            pause = (k >= 1) && (k <= 5);
            tick();
        end
        chk_all("pause_end", 32'h3200, 16'd2, 1'b0, 1'b1, 1'b0);

        // start and abort together in idle
        start = 1'b1; abort = 1'b1; f_start = 32'h7777;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_all("start_abort", 32'h3200, 16'd2, 1'b0, 1'b0, 1'b0);

        // single word, dwell 1
        f_start = 32'h4000; n_steps = 16'd0; dwell = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("single0", 32'h4000, 16'd0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("single_end", 32'h4000, 16'd0, 1'b0, 1'b1, 1'b0);

        // reset mid-sweep at step 2, then restart
        f_start = 32'h1000; f_step = 32'h100; n_steps = 16'd3;
        dwell = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk_all("pre_reset", 32'h1200, 16'd2, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all("mid_reset", 32'h0, 16'd0, 1'b0, 1'b0, 1'b0);
        f_start = 32'h5000; f_step = 32'h1; n_steps = 16'd1;
        dwell = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("restart0", 32'h5000, 16'd0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("restart1", 32'h5001, 16'd1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("restart_end", 32'h5001, 16'd1, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Frequency-sweep sequencer that drives the 32-bit `phase_inc` input of the PLL's NCO. It steps the tuning word from a start value by a signed increment, holds each value for a programmable dwell, and supports one-shot or repeating sweeps. A start/busy/done handshake makes it usable for PLL acquisition sweeps and for open-loop frequency-response test.

## Interface
- `PHASE_W`, 32: tuning-word width; must match the NCO accumulator.
- `CNT_W`, 16: width of the step count, dwell, and step index.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: sampled only in IDLE; latches the configuration and begins a sweep.
- `abort`  in  1: stops a sweep immediately; no `done`.
- `pause`  in  1: while high in RUN, freezes the dwell counter and holds `phase_inc`.
- `repeat_en`  in  1: 0 = one-shot; 1 = restart from `f_start` after the last step.
- `f_start`  in  PHASE_W: first tuning word.
- `f_step`  in  PHASE_W: signed two's-complement increment per step.
- `n_steps`  in  CNT_W: number of increments; the sweep visits `n_steps+1` words.
- `dwell`  in  CNT_W: cycles each word is held; 0 is treated as 1.
- `phase_inc`  out  PHASE_W: to the NCO.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse at sweep completion.
- `step_strobe`  out  1: one-cycle pulse whenever `phase_inc` is loaded with a new sweep value.
- `step_idx`  out  CNT_W: index of the word currently on `phase_inc`.

## Operation
- States: IDLE and RUN.
- **Reset:** state IDLE; `phase_inc`=0, `busy`=0, `done`=0, `step_strobe`=0, `step_idx`=0; dwell counter 0; latched config 0.
- **IDLE → RUN** on `start`=1 with `abort`=0:
  - Latch `f_step`, `n_steps`, `D`=max(`dwell`,1), `repeat_en`, `f_start`.
  - Load `phase_inc`←`f_start`, `step_idx`←0, dwell counter←D−1.
  - Assert `step_strobe` and `busy`.
- **RUN, `pause`=0, counter≠0:** counter decrements.
- **RUN, `pause`=0, counter=0, `step_idx`<`n_steps`:**
  - `phase_inc`←`phase_inc`+`f_step`, mod 2^PHASE_W; wrap is legal and silent.
  - `step_idx`+1, counter←D−1, `step_strobe` pulses.
- **RUN, `pause`=0, counter=0, `step_idx`=`n_steps`:**
  - `done` pulses for one cycle.
  - If latched `repeat_en`=1: reload as on start, from latched `f_start`, with `step_strobe`; stay RUN.
  - Else: go to IDLE, `busy`←0, `phase_inc` holds the last word so the NCO keeps running.
- **`pause`=1 in RUN:** all state frozen. `abort` still acts.
- **`abort`=1 in RUN:** IDLE next edge; `busy`←0; `phase_inc` and `step_idx` hold; no `done`, no `step_strobe`. Abort has priority over step, completion, and pause.
- **`start` in RUN:** ignored. **`start`+`abort` in IDLE:** abort wins, stays IDLE.
- **Config changes mid-sweep:** no effect; only latched values are used.
- **Reset mid-sweep:** returns to reset values on the next edge, including `phase_inc`=0.
- **`n_steps`=0:** single word held D cycles, then `done`.

## Timing
- Outputs are registered. `start` sampled at edge T gives `phase_inc`=`f_start`, `busy`=1, `step_strobe`=1 after edge T.
- With no pause, each word is present for exactly D cycles.
- A one-shot sweep lasts (`n_steps`+1)·D cycles from the first `step_strobe` to `busy` falling. `done` is high in the first cycle `busy` is low.
- In repeat mode, `done` and the reload `step_strobe` share the same cycle, and `busy` stays high.
- Earliest restart: `start` can be accepted the cycle after `busy` falls.
- NCO accumulator and LUT latency are downstream and outside this block.

## Structure
- Package `nco_ctrl_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_RUN`);
  - `PHASE_W_DEF`=32 and `CNT_W_DEF`=16;
  - a packed config struct (`f_start`, `f_step`, `n_steps`, `dwell`, `repeat_en`) used for the latch.
- One natural sub-module, `dwell_timer`: a loadable down-counter with `load`, `load_val`, `en` (= RUN & ~`pause`), and `zero` outputs.

## Test plan
- **One-shot sweep:** `f_start`=0x1000, `f_step`=0x100, `n_steps`=3, `dwell`=4 → `phase_inc` = 0x1000/0x1100/0x1200/0x1300, 4 cycles each, 4 strobes, `step_idx` 0..3, `done` 16 cycles after the first strobe.
- **Negative step with wrap:** `f_start`=0x00000080, `f_step`=−0x100, `n_steps`=1, `dwell`=0 → words 0x00000080 then 0xFFFFFF80, 1 cycle each, then `done`.
- **Repeat mode:** `n_steps`=1, `dwell`=2, `repeat_en`=1 → pattern A,A,B,B,A,A…; `done` pulses every 4 cycles and `busy` never drops. Then `abort` → IDLE, `phase_inc` holds, no `done`.
- **Pause:** `pause` high for 5 cycles mid-dwell (`dwell`=3, `n_steps`=2) → `phase_inc` held 8 cycles on that word; total sweep 14 cycles.
- **Handshake edges:**
  - `start` while `busy` → ignored.
  - `start`+`abort` in IDLE → stays IDLE.
  - `n_steps`=0, `dwell`=1 → one strobe and `done` one cycle later.
- **Reset mid-sweep:** at step 2 → next cycle all outputs 0 and IDLE; the following `start` behaves normally.
